// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer for the 8-bit pipelined core: warm-up after reset,
// load-use stalls, PC-relative jump select, and HALT/resume.
module fetch_sequencer #(
   parameter logic [1:0]  JMP_OP      = 2'b11,
   parameter logic [7:0]  HALT_CODE   = 8'hFF,
   parameter int unsigned INIT_CYCLES = 4,
   parameter int unsigned LOAD_LAT    = 2
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic [7:0] Instruction_Code,
   input  logic [7:0] IFID_Instr,
   input  logic       EX_MemRead,
   input  logic [2:0] EX_Rd,
   input  logic       Resume,
   output logic       PCSrc,
   output logic       ImmSel,
   output logic       PC_En,
   output logic       IFID_Write,
   output logic       IFID_Flush,
   output logic       IDEX_Bubble,
   output logic       Halted
);

   typedef enum logic [1:0] {
      S_INIT  = 2'd0,
      S_RUN   = 2'd1,
      S_STALL = 2'd2,
      S_HALT  = 2'd3
   } state_t;

   localparam logic [3:0] INIT_LAST   = 4'(INIT_CYCLES - 1);
   // The hazard cycle itself is the first frozen cycle, so STALL counts LOAD_LAT-1 more.
   localparam bit         MULTI_STALL = (LOAD_LAT > 1);
   localparam logic [3:0] STALL_LOAD  = MULTI_STALL ? 4'(LOAD_LAT - 2) : 4'd0;

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;

   logic hazard;
   logic halt_req;
   logic jump_req;

   assign hazard   = EX_MemRead && ((EX_Rd == IFID_Instr[5:3]) || (EX_Rd == IFID_Instr[2:0]));
   assign halt_req = (Instruction_Code == HALT_CODE);
   assign jump_req = (Instruction_Code[7:6] == JMP_OP);

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q <= S_INIT;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_INIT: begin
            if (cnt_q == INIT_LAST) begin
               state_d = S_RUN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         S_RUN: begin
            if (hazard) begin
               if (MULTI_STALL) begin
                  state_d = S_STALL;
                  cnt_d   = STALL_LOAD;
               end
            end else if (halt_req) begin
               state_d = S_HALT;
            end
         end
         S_STALL: begin
            if (cnt_q == 4'd0) begin
               state_d = S_RUN;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_HALT: begin
            if (Resume) begin
               state_d = S_RUN;
            end
         end
         default: begin
            state_d = S_INIT;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      PCSrc       = 1'b0;
      ImmSel      = 1'b0;
      PC_En       = 1'b0;
      IFID_Write  = 1'b0;
      IFID_Flush  = 1'b0;
      IDEX_Bubble = 1'b0;
      Halted      = 1'b0;
      case (state_q)
         S_INIT: begin
            IFID_Flush  = 1'b1;
            IDEX_Bubble = 1'b1;
         end
         S_RUN: begin
            if (hazard) begin
               IDEX_Bubble = 1'b1;
            end else if (halt_req) begin
               IFID_Flush = 1'b1;
            end else if (jump_req) begin
               // Jump resolves in IF, so the fetched word is still valid to latch.
               PCSrc      = 1'b1;
               ImmSel     = 1'b1;
               PC_En      = 1'b1;
               IFID_Write = 1'b1;
            end else begin
               PC_En      = 1'b1;
               IFID_Write = 1'b1;
            end
         end
         S_STALL: begin
            // Bubble already sits in EX; just keep PC and IF/ID frozen.
         end
         S_HALT: begin
            Halted     = 1'b1;
            IFID_Flush = 1'b1;
            PC_En      = Resume;
         end
         default: begin
            IFID_Flush  = 1'b1;
            IDEX_Bubble = 1'b1;
         end
      endcase
   end

endmodule
